// File: rtl/fpmul_arb_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter.
// The requester index is carried in a 3-bit field, which covers up to 8 requesters.
package fpmul_arb_pkg;

    localparam int FP_W  = 32;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Saturating increment used by the optional statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fpmul_arbiter_rr.sv
// Combinational round-robin arbiter.
// The search starts one position past ptr and wraps, so the last winner has
// the lowest priority on the next cycle.
module rr_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

    // Walk the requesters in priority order from ptr+1 and grant the first one asking.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
                    found      = 1'b1;
                    gnt[i]     = 1'b1;
                    gnt_idx    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin scheduler sharing one pipelined FP32 multiplier among NUM_REQ
// requesters. A tag pipe follows every issued operation through the
// multiplier so its product is routed back to the right owner, and a drain
// handshake lets upstream control quiesce the datapath.
// Optional feature macro: FPMUL_ARB_STATS_EN adds stat_issued / stat_contend.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic                    mul_valid,
    output logic [FP_W-1:0]         mul_a,
    output logic [FP_W-1:0]         mul_b,
    input  logic [FP_W-1:0]         mul_result,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_result,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic                    busy
`ifdef FPMUL_ARB_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_contend
`endif
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             xfer;
    logic [FP_W-1:0]  sel_a;
    logic [FP_W-1:0]  sel_b;
    logic [IDX_W-1:0] issue_idx;
    tag_t             tag_pipe [MUL_LAT];
    tag_t             tag_out;
    logic             tag_any;
    logic [NUM_REQ-1:0] rsp_valid_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Handshake: only the granted requester is ready, and only while running without drain.
    always_comb begin
        req_ready = '0;
        if (!rst && (state == ST_RUN) && !drain_req) begin
            req_ready = gnt;
        end
        xfer = |(req_valid & req_ready);
    end

    // Pick the granted requester's operands for the issue register.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[FP_W*i +: FP_W];
                sel_b = req_b[FP_W*i +: FP_W];
            end
        end
    end

    // Tag leaving the pipe lines up with mul_result; decode it to a one-hot response.
    always_comb begin
        tag_out     = tag_pipe[MUL_LAT-1];
        tag_any     = 1'b0;
        rsp_valid_d = '0;
        for (int s = 0; s < MUL_LAT; s++) begin
            tag_any = tag_any | tag_pipe[s].vld;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = tag_out.vld && (tag_out.idx == IDX_W'(i));
        end
        busy = mul_valid | tag_any | (|rsp_valid);
    end

    // Pointer, issue register, tag pipe and response register; reset discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            mul_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            issue_idx  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            mul_valid <= xfer;
            if (xfer) begin
                rr_ptr    <= gnt_idx;
                mul_a     <= sel_a;
                mul_b     <= sel_b;
                issue_idx <= gnt_idx;
            end
            tag_pipe[0] <= '{vld: mul_valid, idx: issue_idx};
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
            rsp_valid <= rsp_valid_d;
            if (tag_out.vld) begin
                rsp_result <= mul_result;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state; dropping drain_req always returns to RUN.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (drain_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)  state_next = ST_RUN;
                else if (!busy)  state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!drain_req) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // drain_done reports an empty pipeline as soon as it is empty, not one state later.
    always_comb begin
        drain_done = (state == ST_DONE) ||
                     ((state == ST_DRAIN) && drain_req && !busy);
    end

`ifdef FPMUL_ARB_STATS_EN
    // Saturating counters of transfers and of cycles with contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_contend <= '0;
        end else begin
            if (xfer) begin
                stat_issued <= sat_inc(stat_issued);
            end
            if ($countones(req_valid) >= 2) begin
                stat_contend <= sat_inc(stat_contend);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter with a behavioural FP32 multiplier
// pipeline and a scoreboard of expected responses.
// Optional feature macro: FPMUL_ARB_STATS_EN (checks the statistics ports).
module tb_fpmul_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a;
    logic [NR*32-1:0] req_b;
    logic            mul_valid;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_result;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_result;
    logic            drain_req;
    logic            drain_done;
    logic            busy;
`ifdef FPMUL_ARB_STATS_EN
    logic [31:0]     stat_issued;
    logic [31:0]     stat_contend;
`endif

    fpmul_arbiter #(.NUM_REQ(NR), .MUL_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_valid  (mul_valid),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy)
`ifdef FPMUL_ARB_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_contend (stat_contend)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          issue_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rsp_seen = 0;
    int          last_rsp_cyc = 0;
    logic [31:0] last_rsp_res = '0;
    logic [NR-1:0] last_rsp_vld = '0;
    logic [NR-1:0] acc_mask = '0;
    logic [NR-1:0] ready_seen = '0;
    int          remaining [NR];
    logic [31:0] cur_a [NR];
    logic [31:0] cur_b [NR];
    logic [31:0] mpipe [LAT];

    // Single-precision multiply for normal operands (truncating), standing in for the datapath.
    function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) return {s, 8'(e + 1), m[46:24]};
        return {s, 8'(e), m[45:23]};
    endfunction

    function automatic logic [31:0] randOp();
        return {1'($urandom), 8'($urandom_range(140, 110)), 23'($urandom)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Multiplier model: MUL_LAT register stages after the issue register.
    always @(posedge clk) begin
        mpipe[0] <= fpMul(mul_a, mul_b);
        for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mul_result = mpipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on transfer, pop and compare on response.
    always @(negedge clk) begin
        acc_mask = req_valid & req_ready;
        if (!rst) begin
            ready_seen = ready_seen | req_ready;
            if (acc_mask != '0) begin
                exp_t e;
                checkOutput("ready_onehot", $countones(acc_mask), 1);
                e.idx = 0;
                for (int i = 0; i < NR; i++) if (acc_mask[i]) e.idx = i;
                e.res = fpMul(req_a[32*e.idx +: 32], req_b[32*e.idx +: 32]);
                e.cyc = cyc;
                sb.push_back(e);
                issue_log.push_back(e.idx);
            end
            if (rsp_valid != '0) begin
                rsp_seen++;
                last_rsp_cyc = cyc;
                last_rsp_res = rsp_result;
                last_rsp_vld = rsp_valid;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("rsp_owner", 32'(rsp_valid), 32'(1 << e.idx));
                    checkOutput("rsp_result", rsp_result, e.res);
                    checkOutput("rsp_latency", 32'(cyc - e.cyc), 32'(LAT + 2));
                end
            end
        end
    end

    task automatic driveInputs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (remaining[i] > 0);
            req_a[32*i +: 32]  = cur_a[i];
            req_b[32*i +: 32]  = cur_b[i];
        end
    endtask

    // Run the requester sources for up to budget cycles; accepted operands are replaced.
    task automatic applyStimulus(input int budget, output int used);
        bit pending;
        used = 0;
        driveInputs();
        pending = 1'b0;
        for (int i = 0; i < NR; i++) if (remaining[i] > 0) pending = 1'b1;
        while (pending && used < budget) begin
            @(posedge clk); #1;
            used++;
            for (int i = 0; i < NR; i++) begin
                if (acc_mask[i]) begin
                    remaining[i]--;
                    cur_a[i] = randOp();
                    cur_b[i] = randOp();
                end
            end
            driveInputs();
            pending = 1'b0;
            for (int i = 0; i < NR; i++) if (remaining[i] > 0) pending = 1'b1;
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(n < budget), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        drain_req = 1'b0;
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0;
            cur_a[i] = randOp();
            cur_b[i] = randOp();
        end
        driveInputs();
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        issue_log.delete();
        ready_seen = '0;
        rst = 1'b0;
    endtask

    task automatic checkGrants(input string tag, input int exp_seq[$]);
        checkOutput({tag, "_count"}, 32'(issue_log.size()), 32'(exp_seq.size()));
        for (int k = 0; k < exp_seq.size(); k++) begin
            checkOutput(tag, 32'((k < issue_log.size()) ? issue_log[k] : -1), 32'(exp_seq[k]));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int used;
        int issued_at_drain;

        // Reset state, with requesters asserting valid to prove ready is held low.
        rst = 1'b1;
        drain_req = 1'b0;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        @(posedge clk); #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_mul_valid", 32'(mul_valid), 32'd0);
        checkOutput("rst_mul_a", mul_a, 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_result", rsp_result, 32'd0);
        checkOutput("rst_drain_done", 32'(drain_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        resetDut();

        // Test 1: single op 3.0 * 2.0 from requester 0.
        $display("[TB] test 1: single operation");
        req_valid = 4'b0001;
        req_a[31:0] = 32'h40400000;
        req_b[31:0] = 32'h40000000;
        #1;
        checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        checkOutput("t1_mul_valid", 32'(mul_valid), 32'd1);
        checkOutput("t1_mul_a", mul_a, 32'h40400000);
        checkOutput("t1_mul_b", mul_b, 32'h40000000);
        @(posedge clk); #1;
        checkOutput("t1_mul_valid_low", 32'(mul_valid), 32'd0);
        checkOutput("t1_mul_a_hold", mul_a, 32'h40400000);
        waitIdle("t1_idle", 20);
        checkOutput("t1_rsp_vld", 32'(last_rsp_vld), 32'h1);
        checkOutput("t1_rsp_res", last_rsp_res, 32'h40C00000);

        // Test 2: all four requesters valid for eight cycles.
        $display("[TB] test 2: full contention");
        resetDut();
        for (int i = 0; i < NR; i++) remaining[i] = 100;
        applyStimulus(8, used);
        for (int i = 0; i < NR; i++) remaining[i] = 0;
        driveInputs();
        checkOutput("t2_cycles", 32'(used), 32'd8);
`ifdef FPMUL_ARB_STATS_EN
        checkOutput("t6_stat_issued", stat_issued, 32'd8);
        checkOutput("t6_stat_contend", stat_contend, 32'd8);
`endif
        checkGrants("t2_grant", '{0, 1, 2, 3, 0, 1, 2, 3});
        waitIdle("t2_idle", 30);

        // Test 3: drain in the middle of a back-to-back stream.
        $display("[TB] test 3: drain");
        resetDut();
        for (int i = 0; i < NR; i++) remaining[i] = 3;
        applyStimulus(5, used);
        drain_req = 1'b1;
        #1;
        checkOutput("t3_ready_forced_low", 32'(req_ready), 32'd0);
        issued_at_drain = issue_log.size();
        checkOutput("t3_issued_before_drain", 32'(issued_at_drain), 32'd5);
        used = 0;
        while (!drain_done && used < 30) begin
            @(negedge clk);
            used++;
        end
        checkOutput("t3_drain_done_seen", 32'(drain_done), 32'd1);
        checkOutput("t3_drain_done_timing", 32'(cyc), 32'(last_rsp_cyc + 1));
        checkOutput("t3_no_issue_in_drain", 32'(issue_log.size()), 32'(issued_at_drain));
        checkOutput("t3_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        drain_req = 1'b0;
        applyStimulus(40, used);
        checkOutput("t3_drain_done_low", 32'(drain_done), 32'd0);
        checkOutput("t3_total_issued", 32'(issue_log.size()), 32'd12);
        waitIdle("t3_idle", 30);

        // Test 4: reset two cycles after an issue discards the op.
        $display("[TB] test 4: reset mid-flight");
        resetDut();
        remaining[0] = 1;
        applyStimulus(5, used);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("t4_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t4_busy_after_rst", 32'(busy), 32'd0);
        used = rsp_seen;
        repeat (12) @(negedge clk);
        checkOutput("t4_no_rsp", 32'(rsp_seen), 32'(used));
        checkOutput("t4_busy_idle", 32'(busy), 32'd0);

        // Test 5: only requesters 0 and 2 active.
        $display("[TB] test 5: sparse requesters");
        resetDut();
        remaining[0] = 2;
        remaining[2] = 2;
        applyStimulus(10, used);
        checkOutput("t5_cycles", 32'(used), 32'd4);
        checkGrants("t5_grant", '{0, 2, 0, 2});
        checkOutput("t5_ready_1_3", 32'(ready_seen & 4'b1010), 32'd0);
        waitIdle("t5_idle", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
